// File: rtl/mini_alu_seq_if.sv
// Handshaked operand/result bundle for mini_alu_seq.
// The master side presents operands and consumes results.
// The slave side is the ALU itself.
interface mini_alu_seq_if #(
  parameter int WIDTH = 4,
  parameter int RES_W = 20
) ();

  // Request channel: one operand pair plus opcode per transaction
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [1:0]       opcode;

  // Response channel: result plus its zero flag
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] result;
  logic             zero;

  // Stimulus source / result sink side
  modport master (
    output in_valid,
    output op1,
    output op2,
    output opcode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  zero
  );

  // ALU side
  modport slave (
    input  in_valid,
    input  op1,
    input  op2,
    input  opcode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output zero
  );

endinterface

// File: rtl/mini_alu_seq.sv
// mini_alu_seq: handshaked add/sub/shift ALU.
// Add and subtract finish in one cycle.
// Shifts move one bit per cycle through an accumulator.
// Only one transaction is in flight: the block accepts a request in IDLE.
// It then holds the result in DONE until the sink takes it.
module mini_alu_seq #(
  parameter int WIDTH = 4,
  parameter int RES_W = 20
) (
  input  logic          clk,
  input  logic          rst,
  mini_alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SHL = 2'b10,
    OP_SHR = 2'b11
  } opcode_t;

  state_t           state;
  state_t           state_n;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] acc_n;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_n;
  logic             shift_left;
  logic             shift_left_n;
  logic [RES_W-1:0] result_q;
  logic [RES_W-1:0] result_n;
  logic             zero_q;
  logic             zero_n;

  logic [RES_W-1:0] op1_ext;
  logic [RES_W-1:0] op2_ext;
  logic [RES_W-1:0] shifted;

  // Operands widened to result width; subtraction wraps here, which yields the sign-extended difference
  always_comb begin
    op1_ext = RES_W'(bus.op1);
    op2_ext = RES_W'(bus.op2);
  end

  // One-bit step of the accumulator; shl drops the bit that leaves the top, both directions fill with 0
  always_comb begin
    if (shift_left) begin
      shifted = {acc[RES_W-2:0], 1'b0};
    end else begin
      shifted = {1'b0, acc[RES_W-1:1]};
    end
  end

  // Next-state and datapath decisions; the result is written only when entering DONE
  always_comb begin
    state_n      = state;
    acc_n        = acc;
    cnt_n        = cnt;
    shift_left_n = shift_left;
    result_n     = result_q;
    zero_n       = zero_q;

    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          case (opcode_t'(bus.opcode))
            OP_ADD: begin
              result_n = op1_ext + op2_ext;
              zero_n   = ((op1_ext + op2_ext) == '0);
              state_n  = DONE;
            end
            OP_SUB: begin
              result_n = op1_ext - op2_ext;
              zero_n   = ((op1_ext - op2_ext) == '0);
              state_n  = DONE;
            end
            default: begin
              // Shifts: a zero count gives op1 unchanged, so it skips the SHIFT state entirely
              if (bus.op2 == '0) begin
                result_n = op1_ext;
                zero_n   = (op1_ext == '0);
                state_n  = DONE;
              end else begin
                acc_n        = op1_ext;
                cnt_n        = bus.op2;
                shift_left_n = (opcode_t'(bus.opcode) == OP_SHL);
                state_n      = SHIFT;
              end
            end
          endcase
        end
      end

      SHIFT: begin
        acc_n = shifted;
        cnt_n = cnt - WIDTH'(1);
        // Last step: publish the post-shift value in the same cycle the count reaches zero
        if (cnt == WIDTH'(1)) begin
          result_n = shifted;
          zero_n   = (shifted == '0);
          state_n  = DONE;
        end
      end

      DONE: begin
        // Result is held until the sink accepts it; zero must not remain asserted once out_valid drops
        if (bus.out_ready) begin
          zero_n  = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset takes priority over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      shift_left <= shift_left_n;
      result_q   <= result_n;
      zero_q     <= zero_n;
    end
  end

  // Handshake outputs come straight from the state, so they never glitch on input changes
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.result    = result_q;
    bus.zero      = zero_q;
  end

endmodule

// File: tb/tb_mini_alu_seq.sv
// Self-checking bench for mini_alu_seq.
// Contains a vector table, hand-written back-pressure and reset sequences, and random back-to-back ops.
// The random ops are checked against an arithmetic reference model.
module tb_mini_alu_seq;

  localparam int WIDTH = 4;
  localparam int RES_W = 20;

  logic clk;
  logic rst;

  int nChecks;
  int nFails;

  mini_alu_seq_if #(.WIDTH(WIDTH), .RES_W(RES_W)) bus ();

  mini_alu_seq #(.WIDTH(WIDTH), .RES_W(RES_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some sequence wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    int         a;
    int         b;
    int         opc;
    logic [19:0] expResult;
    logic        expZero;
    int          expLat;
  } vector_t;

  vector_t vectors[$];

  // Reference model computed from the operation definitions
  function automatic logic [19:0] refResult(input int a, input int b, input int opc);
    longint v;
    case (opc)
      0:       v = longint'(a) + longint'(b);
      1:       v = longint'(a) - longint'(b);
      2:       v = longint'(a) << b;
      default: v = longint'(a) >> b;
    endcase
    return v[19:0];
  endfunction

  // Cycles from the accept edge to the first edge that sees out_valid
  function automatic int refLatency(input int b, input int opc);
    if (opc >= 2) return 1 + b;
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op while the DUT is idle and wait for its result.
  // When keepValid is set, in_valid stays high and junk operands appear every cycle;
  // the DUT must ignore them.
  task automatic applyStimulus(input int a, input int b, input int opc, input bit keepValid,
                               output logic [19:0] res, output logic zf, output int lat);
    checkOutput("in_ready before accept", 32'(bus.in_ready), 32'd1);
    bus.op1      = 4'(a);
    bus.op2      = 4'(b);
    bus.opcode   = 2'(opc);
    bus.in_valid = 1'b1;
    tick();
    lat = 1;
    if (!keepValid) bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      if (keepValid) begin
        bus.op1    = 4'($urandom_range(15));
        bus.op2    = 4'($urandom_range(15));
        bus.opcode = 2'($urandom_range(3));
      end
      tick();
      lat++;
    end
    res = bus.result;
    zf  = bus.zero;
  endtask

  initial begin
    logic [19:0] res;
    logic        zf;
    logic [19:0] held;
    int          lat;
    int          a;
    int          b;
    int          opc;
    bit          sawValid;

    nChecks = 0;
    nFails  = 0;

    vectors.push_back('{9, 7, 0, 20'h00010, 1'b0, 1});
    vectors.push_back('{3, 5, 1, 20'hFFFFE, 1'b0, 1});
    vectors.push_back('{6, 6, 1, 20'h00000, 1'b1, 1});
    vectors.push_back('{15, 15, 2, 20'h78000, 1'b0, 16});
    vectors.push_back('{12, 2, 3, 20'h00003, 1'b0, 3});
    vectors.push_back('{5, 0, 2, 20'h00005, 1'b0, 1});
    vectors.push_back('{1, 1, 3, 20'h00000, 1'b1, 2});
    vectors.push_back('{15, 15, 0, 20'h0001E, 1'b0, 1});
    vectors.push_back('{0, 0, 0, 20'h00000, 1'b1, 1});
    vectors.push_back('{0, 15, 1, 20'hFFFF1, 1'b0, 1});
    vectors.push_back('{0, 0, 3, 20'h00000, 1'b1, 1});
    vectors.push_back('{9, 4, 2, 20'h00090, 1'b0, 5});

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset result", 32'(bus.result), 32'd0);
    checkOutput("reset zero", 32'(bus.zero), 32'd0);

    $display("[TB] vector table");
    foreach (vectors[i]) begin
      applyStimulus(vectors[i].a, vectors[i].b, vectors[i].opc, 1'b0, res, zf, lat);
      checkOutput($sformatf("vec%0d result", i), 32'(res), 32'(vectors[i].expResult));
      checkOutput($sformatf("vec%0d zero", i), 32'(zf), 32'(vectors[i].expZero));
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vectors[i].expLat));
      tick();
      checkOutput($sformatf("vec%0d out_valid drop", i), 32'(bus.out_valid), 32'd0);
      checkOutput($sformatf("vec%0d zero drop", i), 32'(bus.zero), 32'd0);
    end

    $display("[TB] back-pressure");
    bus.out_ready = 1'b0;
    applyStimulus(9, 7, 0, 1'b0, res, zf, lat);
    held = res;
    checkOutput("bp first result", 32'(res), 32'h00010);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.op1      = 4'(3);
      bus.op2      = 4'(5);
      bus.opcode   = 2'(1);
      tick();
      checkOutput($sformatf("bp%0d out_valid", c), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("bp%0d in_ready", c), 32'(bus.in_ready), 32'd0);
      checkOutput($sformatf("bp%0d result", c), 32'(bus.result), 32'(held));
      checkOutput($sformatf("bp%0d zero", c), 32'(bus.zero), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bp release out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("bp release in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("bp ignored op not run", 32'(bus.out_valid), 32'd0);

    $display("[TB] reset mid-shift");
    bus.op1      = 4'(1);
    bus.op2      = 4'(10);
    bus.opcode   = 2'(2);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid-shift rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid-shift rst in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("mid-shift rst result", 32'(bus.result), 32'd0);
    sawValid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("mid-shift no result emitted", 32'(sawValid), 32'd0);

    $display("[TB] reset during DONE handshake");
    applyStimulus(9, 7, 0, 1'b0, res, zf, lat);
    checkOutput("done-rst pre result", 32'(res), 32'h00010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("done-rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("done-rst result", 32'(bus.result), 32'd0);
    checkOutput("done-rst in_ready", 32'(bus.in_ready), 32'd1);

    $display("[TB] random back-to-back");
    for (int n = 0; n < 20; n++) begin
      a   = int'($urandom_range(15));
      b   = int'($urandom_range(15));
      opc = int'($urandom_range(3));
      applyStimulus(a, b, opc, 1'b1, res, zf, lat);
      checkOutput($sformatf("rnd%0d result op%0d %0d,%0d", n, opc, a, b), 32'(res), 32'(refResult(a, b, opc)));
      checkOutput($sformatf("rnd%0d zero", n), 32'(zf), 32'(refResult(a, b, opc) == 20'd0));
      checkOutput($sformatf("rnd%0d latency", n), 32'(lat), 32'(refLatency(b, opc)));
      bus.op1    = 4'($urandom_range(15));
      bus.op2    = 4'($urandom_range(15));
      bus.opcode = 2'($urandom_range(3));
      tick();
      checkOutput($sformatf("rnd%0d back to idle", n), 32'(bus.out_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
